// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer: shares one external 4-bit adder slice between two
// requesters. Each N-bit add is run LSB chunk first, one 4-bit chunk per
// clock, with the inter-chunk carry held in carry_r. Round-robin arbitration
// in IDLE, result presented in DONE until the consumer takes it.
// Optional build macro: SIGNED_OVF_EN adds the rsp_ovf signed-overflow port.
module adder_slice_sequencer #(
  parameter int N = 12
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_A,
  input  logic [N-1:0] req0_B,
  input  logic         req0_ci,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_A,
  input  logic [N-1:0] req1_B,
  input  logic         req1_ci,
  output logic [3:0]   add_A,
  output logic [3:0]   add_B,
  output logic         add_ci,
  input  logic [3:0]   add_SUM,
  input  logic         add_co,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_SUM,
  output logic         rsp_co
`ifdef SIGNED_OVF_EN
  ,
  output logic         rsp_ovf
`endif
);

  localparam int CHUNKS = N / 4;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [N-1:0]   sum_r;
  logic           ci_r;
  logic           id_r;
  logic           carry_r;
  logic [CW-1:0]  cnt_r;
  logic           last_grant_r;
  logic           any_valid_s;
  logic           grant_id_s;
  logic           accept_s;

  assign any_valid_s = req0_valid | req1_valid;
  assign accept_s    = (state_r == IDLE) && any_valid_s;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: accept in IDLE, walk the chunks in RUN, wait for the consumer in DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operation datapath: latch the granted request, then collect one sum chunk per RUN cycle.
  always_ff @(posedge CK) begin
    if (RST) begin
      a_r          <= '0;
      b_r          <= '0;
      sum_r        <= '0;
      ci_r         <= 1'b0;
      id_r         <= 1'b0;
      carry_r      <= 1'b0;
      cnt_r        <= '0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      a_r          <= grant_id_s ? req1_A  : req0_A;
      b_r          <= grant_id_s ? req1_B  : req0_B;
      ci_r         <= grant_id_s ? req1_ci : req0_ci;
      id_r         <= grant_id_s;
      cnt_r        <= '0;
      last_grant_r <= grant_id_s;
    end else if (state_r == RUN) begin
      for (int i = 0; i < CHUNKS; i++) begin
        if (cnt_r == CW'(i)) begin
          sum_r[4*i +: 4] <= add_SUM;
        end
      end
      carry_r <= add_co;
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  // Output decode: readies only in IDLE, slice drive only in RUN, response only in DONE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    add_A      = 4'h0;
    add_B      = 4'h0;
    add_ci     = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_SUM    = '0;
    rsp_co     = 1'b0;
`ifdef SIGNED_OVF_EN
    rsp_ovf    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        req0_ready = any_valid_s && !grant_id_s;
        req1_ready = any_valid_s && grant_id_s;
      end
      RUN: begin
        for (int i = 0; i < CHUNKS; i++) begin
          if (cnt_r == CW'(i)) begin
            add_A = a_r[4*i +: 4];
            add_B = b_r[4*i +: 4];
          end
        end
        if (cnt_r == '0) begin
          add_ci = ci_r;
        end else begin
          add_ci = carry_r;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id_r;
        rsp_SUM   = sum_r;
        rsp_co    = carry_r;
`ifdef SIGNED_OVF_EN
        rsp_ovf   = (a_r[N-1] == b_r[N-1]) && (sum_r[N-1] != a_r[N-1]);
`endif
      end
      default: begin
        rsp_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Self-checking bench for adder_slice_sequencer (N=12). A behavioural 4-bit
// slice is attached to the add_* port; expected results come from whole-word
// integer arithmetic and a bench-side round-robin model.
module tb_adder_slice_sequencer;

  localparam int N = 12;
  localparam int CHUNKS = N / 4;

  logic         CK = 1'b0;
  logic         RST;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0] req0_A, req0_B, req1_A, req1_B;
  logic         req0_ci, req1_ci;
  logic [3:0]   add_A, add_B, add_SUM;
  logic         add_ci, add_co;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_co;
  logic [N-1:0] rsp_SUM;
`ifdef SIGNED_OVF_EN
  logic         rsp_ovf;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic         lg;           // bench model of the last granted requester
  logic [N-1:0] op_a [2];
  logic [N-1:0] op_b [2];
  logic         op_ci [2];

  adder_slice_sequencer #(.N(N)) dut (
    .CK(CK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_ci(req0_ci),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_ci(req1_ci),
    .add_A(add_A), .add_B(add_B), .add_ci(add_ci), .add_SUM(add_SUM), .add_co(add_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_SUM(rsp_SUM), .rsp_co(rsp_co)
`ifdef SIGNED_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  always #5 CK = ~CK;

  // The shared 4-bit slice.
  assign {add_co, add_SUM} = {1'b0, add_A} + {1'b0, add_B} + {4'h0, add_ci};

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    v = {6'd0, req0_ready, req1_ready, add_A, add_B, add_ci, rsp_valid, rsp_id, rsp_SUM, rsp_co};
    chk(tag, v, 32'd0);
`ifdef SIGNED_OVF_EN
    chk({tag, "_ovf"}, rsp_ovf, 1'b0);
`endif
  endtask

  // Present the requested valids, run the granted operation to completion,
  // keep the response waiting for 'hold' cycles, then take it.
  task automatic run_pair(input logic v0, input logic v1, input int hold);
    logic         w;
    logic [N-1:0] ea, eb, exp_sum;
    logic         eci, exp_co, exp_c;
    int           tot, lat, m, s;
    logic         ci_log [10];
    req0_A = op_a[0]; req0_B = op_b[0]; req0_ci = op_ci[0];
    req1_A = op_a[1]; req1_B = op_b[1]; req1_ci = op_ci[1];
    req0_valid = v0; req1_valid = v1;
    #1;
    w = (v0 && v1) ? ~lg : v1;
    chk("req0_ready", req0_ready, !w);
    chk("req1_ready", req1_ready, w);
    ea = op_a[w]; eb = op_b[w]; eci = op_ci[w];
    tick;
    lg = w;
    // Winner withdraws and scribbles over its operands; the latched copy must be used.
    if (w) begin
      req1_valid = 1'b0; req1_A = N'($urandom); req1_B = N'($urandom); req1_ci = 1'($urandom);
    end else begin
      req0_valid = 1'b0; req0_A = N'($urandom); req0_B = N'($urandom); req0_ci = 1'($urandom);
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      chk("run_readies", {req0_ready, req1_ready}, 2'b00);
      ci_log[lat] = add_ci;
      tick;
      lat++;
    end
    chk("latency", lat, CHUNKS);
    for (int i = 0; i < CHUNKS && i < lat; i++) begin
      if (i == 0) begin
        exp_c = eci;
      end else begin
        m = (1 << (4 * i)) - 1;
        s = (int'(ea) & m) + (int'(eb) & m) + int'(eci);
        exp_c = 1'((s >> (4 * i)) & 1);
      end
      chk("chunk_ci", ci_log[i], exp_c);
    end
    tot = int'(ea) + int'(eb) + int'(eci);
    exp_sum = tot[N-1:0];
    exp_co = tot[N];
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, w);
    chk("rsp_SUM", rsp_SUM, exp_sum);
    chk("rsp_co", rsp_co, exp_co);
`ifdef SIGNED_OVF_EN
    chk("rsp_ovf", rsp_ovf, (ea[N-1] == eb[N-1]) && (exp_sum[N-1] != ea[N-1]));
`endif
    chk("done_slice_idle", {add_A, add_B, add_ci}, 9'd0);
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_SUM", rsp_SUM, exp_sum);
      chk("hold_readies", {req0_ready, req1_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("back_to_idle", rsp_valid, 1'b0);
  endtask

  initial begin
    RST = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_A = '0; req0_B = '0; req0_ci = 1'b0;
    req1_A = '0; req1_B = '0; req1_ci = 1'b0;
    lg = 1'b1;
    tick; tick;
    RST = 1'b0;
    #1;
    check_all_zero("reset_outputs");

    // Tie straight from reset: req0 first, then alternation.
    op_a[0] = 12'h001; op_b[0] = 12'h002; op_ci[0] = 1'b0;
    op_a[1] = 12'h100; op_b[1] = 12'h200; op_ci[1] = 1'b0;
    run_pair(1'b1, 1'b1, 0);
    op_a[0] = 12'h123; op_b[0] = 12'h456;
    run_pair(1'b1, 1'b1, 0);
    op_a[1] = 12'hABC; op_b[1] = 12'h111;
    run_pair(1'b1, 1'b1, 0);

    // Full-width carry out.
    op_a[0] = 12'hFFF; op_b[0] = 12'h001; op_ci[0] = 1'b0;
    run_pair(1'b1, 1'b0, 0);
    // Inter-chunk carry: slice carry-ins 1,0,1.
    op_a[0] = 12'h0F0; op_b[0] = 12'h010; op_ci[0] = 1'b1;
    run_pair(1'b1, 1'b0, 0);
    // Consumer stalls for 5 cycles.
    op_a[1] = 12'h9A5; op_b[1] = 12'h7C3; op_ci[1] = 1'b1;
    run_pair(1'b0, 1'b1, 5);

    // Random traffic.
    for (int k = 0; k < 12; k++) begin
      int sel;
      sel = $urandom_range(1, 3);
      for (int j = 0; j < 2; j++) begin
        op_a[j] = N'($urandom); op_b[j] = N'($urandom); op_ci[j] = 1'($urandom);
      end
      run_pair(1'(sel & 1), 1'((sel >> 1) & 1), $urandom_range(0, 2));
    end

    // Reset in RUN at cnt=1 after a req0 grant; then a tie must go to req0 immediately.
    op_a[0] = 12'h555; op_b[0] = 12'h333; op_ci[0] = 1'b0;
    req0_A = op_a[0]; req0_B = op_b[0]; req0_ci = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    #1;
    tick;
    req0_valid = 1'b0;
    tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    lg = 1'b1;
    #1;
    check_all_zero("reset_mid_run");
    op_a[0] = 12'h00F; op_b[0] = 12'h001; op_ci[0] = 1'b0;
    op_a[1] = 12'h0F0; op_b[1] = 12'h010; op_ci[1] = 1'b0;
    run_pair(1'b1, 1'b1, 0);

    // Reset while the response is waiting: it must never come back.
    req1_A = 12'h222; req1_B = 12'h444; req1_ci = 1'b0;
    req1_valid = 1'b1;
    #1;
    tick;
    req1_valid = 1'b0;
    for (int i = 0; i < CHUNKS; i++) tick;
    chk("pre_reset_done", rsp_valid, 1'b1);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    lg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("no_rsp_after_reset", rsp_valid, 1'b0);
      tick;
    end
    check_all_zero("reset_in_done");

`ifdef SIGNED_OVF_EN
    op_a[0] = 12'h7FF; op_b[0] = 12'h001; op_ci[0] = 1'b0;
    run_pair(1'b1, 1'b0, 0);
    op_a[0] = 12'h7FE; op_b[0] = 12'h001; op_ci[0] = 1'b0;
    run_pair(1'b1, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
